puf_crp_sequencer: RTL and testbench
====================================

# puf_crp_sequencer

Challenge-side controller for the arbiter PUF array. It generates challenges from an LFSR and drives them onto the PUF challenge bus. For each challenge it fires repeated evaluation pulses, synchronises and majority-votes the PUF response over several evaluations, and streams (challenge, response) pairs out over a valid/ready interface. It sits between the PUF macro and any consumer: an enrollment logger, a key extractor or an IO serializer.

## Interface
Parameters:
- C_LENGTH, 8: challenge and response width in bits.
- N_EVAL, 5: evaluations per challenge. Must be odd and ≥1.
- SETTLE, 4: cycles for each pulse phase (low, then high). Must be ≥1.

Ports:
- clk  in  1  system clock. The design has one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a run. Ignored while busy=1.
- seed  in  C_LENGTH  LFSR seed, sampled when start is accepted. A seed of 0 is replaced by 1.
- num_chal  in  8  number of challenges in the run, sampled with start. 0 means 256.
- puf_pulse  out  1  evaluation pulse to the PUF. Rising edge launches the race.
- puf_challenge  out  C_LENGTH  challenge to the PUF. Stable during every pulse.
- puf_response  in  C_LENGTH  raw PUF response. Asynchronous to clk.
- resp_valid  out  1  a (challenge, response) pair is available.
- resp_ready  in  1  consumer accepts the pair.
- resp_chal  out  C_LENGTH  challenge of the current pair.
- resp_data  out  C_LENGTH  majority-voted response.
- busy  out  1  a run is in progress.
- done  out  1  one-cycle pulse after the last pair is accepted.

## Operation
- FSM states: IDLE, LOAD, PULSE_LO, PULSE_HI, SAMPLE, OUTPUT, NEXT.
- IDLE:
  - On start, latch seed (0→1) into the LFSR, latch num_chal into the remaining counter (0→256), and set busy=1.
  - Go to LOAD.
- LOAD:
  - puf_challenge ← LFSR state.
  - Clear the per-bit vote counters and the evaluation counter.
  - Go to PULSE_LO.
- PULSE_LO: puf_pulse=0 for SETTLE cycles, then go to PULSE_HI.
- PULSE_HI: puf_pulse=1 for SETTLE cycles, then go to SAMPLE.
- SAMPLE:
  - puf_pulse stays 1 for 3 cycles: 2 cycles for the synchroniser, then 1 capture cycle.
  - On the capture cycle, each vote counter[i] increments if synced response[i]=1.
  - After capture, the evaluation counter increments.
  - If it is below N_EVAL, go to PULSE_LO; otherwise go to OUTPUT.
- OUTPUT:
  - resp_data[i] = (vote[i] > N_EVAL/2), resp_chal = puf_challenge, resp_valid=1.
  - Hold resp_data and resp_chal stable until resp_valid && resp_ready. Go to NEXT on that cycle.
- NEXT:
  - Advance the LFSR one step and decrement the remaining counter.
  - If remaining was 1: pulse done, clear busy, go to IDLE. Otherwise go to LOAD.
- LFSR: Galois, right shift. next = (s>>1) ^ (s[0] ? 8'hB8 : 0), a maximal-length 255-state sequence for C_LENGTH=8. Runs longer than 255 challenges repeat challenges.
- Vote counter width: $clog2(N_EVAL+1).
- puf_response passes through a 2-flop synchroniser on clk before it is used.
- Reset is asynchronous, from any state. The FSM returns to IDLE and all outputs go to 0, including puf_pulse, puf_challenge, resp_*, busy and done. A reset mid-run abandons the run. No partial pair is emitted.

## Timing
- Each evaluation takes 2·SETTLE+3 cycles (11 at defaults).
- Latency from start accepted to first resp_valid: 1 + 1 + N_EVAL·(2·SETTLE+3) cycles. At defaults this is 57 (IDLE→LOAD, LOAD, evaluations).
- After a handshake, the next resp_valid follows 1 (NEXT) + 1 (LOAD) + N_EVAL·(2·SETTLE+3) cycles later.
- done asserts the cycle after the final handshake, together with busy falling.
- start is accepted again from the following cycle.
- puf_challenge changes only in LOAD, when puf_pulse=0. This gives SETTLE cycles of challenge setup before the first rising pulse edge.
- Backpressure: resp_ready low holds OUTPUT indefinitely, and no pulses are issued during the stall.

## Structure
- A shared package holds the state enum, the LFSR tap constant (8'hB8) and the default parameter values.
- One sub-module: puf_resp_sync, a parameterised 2-flop synchroniser, bank-wide over C_LENGTH.
- Everything else lives in one module.

## Test plan
- PUF model with response = challenge ^ 8'hA5, seed=8'h01, num_chal=2, resp_ready=1:
  - Pairs (01, A4) then (B8, 1D).
  - First resp_valid exactly 57 cycles after start.
  - done pulses once.
- Noise model flipping bit0 of the response on 2 of 5 evaluations → resp_data bit0 unchanged. Flipping on 3 of 5 evaluations → bit0 inverted.
- seed=0, num_chal=1 → resp_chal=8'h01. num_chal=0 → 256 pairs, and the first challenge recurs at pair 256.
- resp_ready held low for 40 cycles in OUTPUT → resp_chal and resp_data stable, puf_pulse=0, no extra pairs; the handshake then completes normally.
- start asserted while busy → ignored; the pair count is still num_chal.
- rst_n low during PULSE_HI of the second evaluation → all outputs 0 immediately. After release the block is in IDLE and a new start runs cleanly.

Source files
------------

// File: rtl/puf_crp_sequencer_pkg.sv
// Shared types and constants for the PUF challenge/response sequencer.
package puf_crp_sequencer_pkg;

   localparam int DEF_C_LENGTH = 8;
   localparam int DEF_N_EVAL   = 5;
   localparam int DEF_SETTLE   = 4;

   // Galois right-shift feedback taps; maximal length for an 8-bit register.
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PULSE_LO,
      ST_PULSE_HI,
      ST_SAMPLE,
      ST_OUTPUT,
      ST_NEXT
   } state_t;

endpackage

// File: rtl/puf_crp_sequencer_if.sv
// Bundle of command, PUF-side and pair-stream signals around the sequencer.
// The sequencer connects through the slave modport; its environment
// (command source, PUF macro, pair consumer) uses the master modport.
interface puf_crp_sequencer_if
   import puf_crp_sequencer_pkg::*;
#(
   parameter int C_LENGTH = DEF_C_LENGTH
);
   logic                start;
   logic [C_LENGTH-1:0] seed;
   logic [7:0]          num_chal;
   logic                puf_pulse;
   logic [C_LENGTH-1:0] puf_challenge;
   logic [C_LENGTH-1:0] puf_response;
   logic                resp_valid;
   logic                resp_ready;
   logic [C_LENGTH-1:0] resp_chal;
   logic [C_LENGTH-1:0] resp_data;
   logic                busy;
   logic                done;

   modport master (
      output start, seed, num_chal, puf_response, resp_ready,
      input  puf_pulse, puf_challenge, resp_valid, resp_chal, resp_data, busy, done
   );

   modport slave (
      input  start, seed, num_chal, puf_response, resp_ready,
      output puf_pulse, puf_challenge, resp_valid, resp_chal, resp_data, busy, done
   );
endinterface

// File: rtl/puf_resp_sync.sv
// Two-flop synchroniser bank for the asynchronous PUF response bits.
module puf_resp_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic meta_q;
         logic sync_q;

         // Two-stage capture of one response bit into the clk domain.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               meta_q <= 1'b0;
               sync_q <= 1'b0;
            end else begin
               meta_q <= d_i[gi];
               sync_q <= meta_q;
            end
         end

         assign q_o[gi] = sync_q;
      end
   endgenerate

endmodule

// File: rtl/puf_crp_sequencer.sv
// Challenge-side controller for an arbiter PUF array: LFSR challenges,
// repeated evaluation pulses, per-bit majority vote, valid/ready pair stream.
module puf_crp_sequencer
   import puf_crp_sequencer_pkg::*;
#(
   parameter int C_LENGTH = DEF_C_LENGTH,
   parameter int N_EVAL   = DEF_N_EVAL,   // odd, >= 1
   parameter int SETTLE   = DEF_SETTLE    // >= 1
) (
   input logic clk,
   input logic rst_n,
   puf_crp_sequencer_if.slave bus
);

   localparam int VOTE_W = $clog2(N_EVAL + 1);
   localparam int EVAL_W = $clog2(N_EVAL + 1);
   localparam int PH_W   = $clog2(SETTLE + 3);

   localparam logic [C_LENGTH-1:0] TAPS      = C_LENGTH'(LFSR_TAPS);
   localparam logic [EVAL_W-1:0]   EVAL_LAST = EVAL_W'(N_EVAL - 1);
   localparam logic [PH_W-1:0]     PH_SETTLE = PH_W'(SETTLE - 1);
   // Two synchroniser cycles followed by the capture cycle.
   localparam logic [PH_W-1:0]     PH_SAMPLE = PH_W'(2);
   localparam logic [VOTE_W-1:0]   VOTE_HALF = VOTE_W'(N_EVAL / 2);

   state_t                          state_q, state_d;
   logic [C_LENGTH-1:0]             lfsr_q, lfsr_d;
   logic [C_LENGTH-1:0]             chal_q, chal_d;
   logic [8:0]                      rem_q, rem_d;
   logic [EVAL_W-1:0]               eval_q, eval_d;
   logic [PH_W-1:0]                 ph_q, ph_d;
   logic [C_LENGTH-1:0][VOTE_W-1:0] votes_q, votes_d;

   logic [C_LENGTH-1:0] resp_sync;
   logic [C_LENGTH-1:0] majority;
   logic [C_LENGTH-1:0] lfsr_step;
   logic                last_pair;

   puf_resp_sync #(
      .WIDTH(C_LENGTH)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (bus.puf_response),
      .q_o  (resp_sync)
   );

   assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

   genvar gi;
   generate
      for (gi = 0; gi < C_LENGTH; gi++) begin : g_vote
         assign majority[gi] = (votes_q[gi] > VOTE_HALF);
      end
   endgenerate

   // State and datapath registers; reset abandons any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         lfsr_q  <= '0;
         chal_q  <= '0;
         rem_q   <= '0;
         eval_q  <= '0;
         ph_q    <= '0;
         votes_q <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         chal_q  <= chal_d;
         rem_q   <= rem_d;
         eval_q  <= eval_d;
         ph_q    <= ph_d;
         votes_q <= votes_d;
      end
   end

   // Next-state logic: challenge load, pulse phases, voting and hand-off.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      chal_d  = chal_q;
      rem_d   = rem_q;
      eval_d  = eval_q;
      ph_d    = ph_q;
      votes_d = votes_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               lfsr_d  = (bus.seed == '0) ? C_LENGTH'(1) : bus.seed;
               rem_d   = (bus.num_chal == 8'd0) ? 9'd256 : {1'b0, bus.num_chal};
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            // The only place the challenge bus moves, always with pulse low.
            chal_d  = lfsr_q;
            votes_d = '0;
            eval_d  = '0;
            ph_d    = '0;
            state_d = ST_PULSE_LO;
         end

         ST_PULSE_LO: begin
            if (ph_q == PH_SETTLE) begin
               ph_d    = '0;
               state_d = ST_PULSE_HI;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end

         ST_PULSE_HI: begin
            if (ph_q == PH_SETTLE) begin
               ph_d    = '0;
               state_d = ST_SAMPLE;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end

         ST_SAMPLE: begin
            if (ph_q == PH_SAMPLE) begin
               ph_d = '0;
               for (int i = 0; i < C_LENGTH; i++) begin
                  votes_d[i] = votes_q[i] + VOTE_W'(resp_sync[i]);
               end
               eval_d  = eval_q + 1'b1;
               state_d = (eval_q == EVAL_LAST) ? ST_OUTPUT : ST_PULSE_LO;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end

         ST_OUTPUT: begin
            if (bus.resp_ready) begin
               state_d = ST_NEXT;
            end
         end

         ST_NEXT: begin
            lfsr_d  = lfsr_step;
            rem_d   = rem_q - 1'b1;
            state_d = (rem_q == 9'd1) ? ST_IDLE : ST_LOAD;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decode directly from registered state so reset clears them at once.
   assign last_pair         = (state_q == ST_NEXT) && (rem_q == 9'd1);
   assign bus.puf_pulse     = (state_q == ST_PULSE_HI) || (state_q == ST_SAMPLE);
   assign bus.puf_challenge = chal_q;
   assign bus.resp_valid    = (state_q == ST_OUTPUT);
   assign bus.resp_chal     = (state_q == ST_OUTPUT) ? chal_q : '0;
   assign bus.resp_data     = (state_q == ST_OUTPUT) ? majority : '0;
   assign bus.done          = last_pair;
   assign bus.busy          = (state_q != ST_IDLE) && !last_pair;

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Directed bench for puf_crp_sequencer: table of runs plus stall/reset cases.
module tb_puf_crp_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   puf_crp_sequencer_if #(.C_LENGTH(8)) bus ();

   puf_crp_sequencer #(
      .C_LENGTH(8),
      .N_EVAL  (5),
      .SETTLE  (4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // PUF model: response = challenge ^ A5, bit0 optionally flipped per evaluation.
   logic [4:0] noise_mask = 5'b0;
   logic       ev_clr     = 1'b0;
   logic       pulse_prev = 1'b0;
   int         ev_idx     = -1;
   logic       flip;

   assign flip = (ev_idx >= 0 && ev_idx < 5) ? noise_mask[ev_idx] : 1'b0;
   assign bus.puf_response = (bus.puf_challenge ^ 8'hA5) ^ {7'b0, flip};

   always @(posedge clk) begin
      if (ev_clr || (bus.resp_valid && bus.resp_ready)) ev_idx <= -1;
      else if (bus.puf_pulse && !pulse_prev)          ev_idx <= ev_idx + 1;
      pulse_prev <= bus.puf_pulse;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
   endfunction

   typedef struct {
      logic [7:0] seed;
      logic [7:0] num;
      logic [4:0] mask;
      int         restart_at;
      logic [7:0] first_c;
      logic [7:0] first_d;
      logic [7:0] last_c;
      logic [7:0] last_d;
      int         pairs;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input int id, input vec_t v);
      int cyc, npairs, ndone, lat, prev_hs, gap_bad, model_bad, idle_bad;
      logic       busy_at_done;
      logic [7:0] m, fc, fd, lc, ld;
      npairs = 0; ndone = 0; lat = -1; prev_hs = 0; gap_bad = 0; model_bad = 0;
      idle_bad = 0; busy_at_done = 1'b1; fc = 0; fd = 0; lc = 0; ld = 0;
      m = (v.seed == 8'h00) ? 8'h01 : v.seed;
      noise_mask = v.mask;
      bus.resp_ready = 1'b1;
      ev_clr = 1'b1;
      @(posedge clk); #1;
      ev_clr = 1'b0;
      bus.seed = v.seed; bus.num_chal = v.num; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 1;
      while (ndone == 0 && cyc < 20000) begin
         if (v.restart_at != 0 && cyc == v.restart_at) begin
            bus.seed = 8'hFF; bus.num_chal = 8'd5; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.resp_valid) begin
            if (npairs == 0) begin
               lat = cyc; fc = bus.resp_chal; fd = bus.resp_data;
            end else if (cyc - (prev_hs + 1) != 57) begin
               gap_bad++;
            end
            if (bus.resp_chal !== m) model_bad++;
            if (v.mask == 5'b0 && bus.resp_data !== (m ^ 8'hA5)) model_bad++;
            lc = bus.resp_chal; ld = bus.resp_data;
            m = lfsr_next(m);
            prev_hs = cyc;
            npairs++;
         end
         if (bus.done) begin
            ndone++;
            busy_at_done = bus.busy;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.start = 1'b0;
      repeat (3) begin
         if (bus.done) ndone++;
         if (bus.busy || bus.resp_valid) idle_bad++;
         @(posedge clk); #1;
      end
      check($sformatf("v%0d latency", id), lat, 57);
      check($sformatf("v%0d pairs", id), npairs, v.pairs);
      check($sformatf("v%0d first_chal", id), fc, v.first_c);
      check($sformatf("v%0d first_data", id), fd, v.first_d);
      check($sformatf("v%0d last_chal", id), lc, v.last_c);
      check($sformatf("v%0d last_data", id), ld, v.last_d);
      check($sformatf("v%0d model_mismatch_count", id), model_bad, 0);
      check($sformatf("v%0d gap_errors", id), gap_bad, 0);
      check($sformatf("v%0d done_count", id), ndone, 1);
      check($sformatf("v%0d busy_at_done", id), busy_at_done, 0);
      check($sformatf("v%0d idle_after", id), idle_bad, 0);
      $display("run v%0d seed=%02h num=%0d mask=%05b: pairs=%0d first=(%02h,%02h) last=(%02h,%02h) latency=%0d",
               id, v.seed, v.num, v.mask, npairs, fc, fd, lc, ld, lat);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n, rises, unstable;
      logic       prev;
      logic [7:0] sc, sd;
      vec_t       rv;

      //          seed   num    mask      rs  first_c first_d last_c last_d pairs
      vecs[0] = '{8'h01, 8'd2,  5'b00000, 0,  8'h01,  8'hA4,  8'hB8, 8'h1D, 2};
      vecs[1] = '{8'h00, 8'd1,  5'b00000, 0,  8'h01,  8'hA4,  8'h01, 8'hA4, 1};
      vecs[2] = '{8'h01, 8'd1,  5'b00011, 0,  8'h01,  8'hA4,  8'h01, 8'hA4, 1};
      vecs[3] = '{8'h01, 8'd1,  5'b10101, 0,  8'h01,  8'hA5,  8'h01, 8'hA5, 1};
      vecs[4] = '{8'h80, 8'd3,  5'b00000, 0,  8'h80,  8'h25,  8'h20, 8'h85, 3};
      vecs[5] = '{8'hFF, 8'd2,  5'b00000, 0,  8'hFF,  8'h5A,  8'hC7, 8'h62, 2};
      vecs[6] = '{8'h5A, 8'd0,  5'b00000, 0,  8'h5A,  8'hFF,  8'h5A, 8'hFF, 256};
      vecs[7] = '{8'h01, 8'd2,  5'b00000, 10, 8'h01,  8'hA4,  8'hB8, 8'h1D, 2};

      bus.start = 1'b0; bus.seed = 8'h00; bus.num_chal = 8'd0; bus.resp_ready = 1'b1;

      // Reset state.
      #2 rst_n = 1'b0;
      #1;
      check("reset outputs", {bus.puf_pulse, bus.puf_challenge, bus.resp_valid, bus.resp_chal,
                              bus.resp_data, bus.busy, bus.done}, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle after reset", {bus.busy, bus.resp_valid, bus.puf_pulse}, 32'h0);

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Backpressure: hold resp_ready low for 40 cycles in OUTPUT.
      noise_mask = 5'b0;
      bus.resp_ready = 1'b0;
      bus.seed = 8'h33; bus.num_chal = 8'd1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 1;
      while (!bus.resp_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("stall valid reached", bus.resp_valid, 1);
      sc = bus.resp_chal; sd = bus.resp_data;
      check("stall chal", sc, 8'h33);
      check("stall data", sd, 8'h96);
      unstable = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (!bus.resp_valid || bus.resp_chal !== sc || bus.resp_data !== sd ||
             bus.puf_pulse || bus.done) unstable++;
      end
      check("stall stable", unstable, 0);
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      check("stall release done/busy/valid", {bus.done, bus.busy, bus.resp_valid}, 32'h4);
      @(posedge clk); #1;
      check("stall idle", {bus.done, bus.busy, bus.resp_valid}, 32'h0);
      $display("stall run: pair=(%02h,%02h) held 40 cycles", sc, sd);

      // Asynchronous reset during PULSE_HI of the second evaluation.
      bus.seed = 8'h01; bus.num_chal = 8'd2; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      rises = 0; prev = 1'b0; n = 0;
      while (rises < 2 && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (bus.puf_pulse && !prev) rises++;
         prev = bus.puf_pulse;
      end
      check("reset test second pulse", rises, 2);
      check("pre-reset pulse/chal/busy", {bus.puf_pulse, bus.puf_challenge, bus.busy}, {22'h0, 1'b1, 8'h01, 1'b1});
      #2 rst_n = 1'b0;
      #1;
      check("mid-run reset outputs", {bus.puf_pulse, bus.puf_challenge, bus.resp_valid, bus.resp_chal,
                                      bus.resp_data, bus.busy, bus.done}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("reset held outputs", {bus.puf_pulse, bus.busy, bus.resp_valid, bus.done}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle after mid-run reset", {bus.busy, bus.puf_pulse, bus.resp_valid}, 32'h0);
      $display("mid-run reset applied after %0d cycles", n);
      rv = '{8'h01, 8'd1, 5'b00000, 0, 8'h01, 8'hA4, 8'h01, 8'hA4, 1};
      run_vec(8, rv);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
